// File: rtl/inst_rom_if.sv
// Fetch and loader bus between the PC register / program loader (master) and inst_rom_ctrl (slave).
interface inst_rom_if;
  logic        ce;
  logic [31:0] pc;
  logic [5:0]  stall;
  logic [31:0] inst;
  logic        inst_valid;
  logic        addr_err;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_done;

  modport master (
    output ce, pc, stall, ld_valid, ld_byte, ld_last,
    input  inst, inst_valid, addr_err, ld_ready, ld_done
  );

  modport slave (
    input  ce, pc, stall, ld_valid, ld_byte, ld_last,
    output inst, inst_valid, addr_err, ld_ready, ld_done
  );
endinterface

// File: rtl/inst_rom_ctrl.sv
// Instruction memory with 1-cycle registered fetch and a byte-serial program loader.
// Optional IMEM_ADDR_CHECK_EN: flag misaligned / out-of-range fetches and return a nop.
module inst_rom_ctrl #(
  parameter int AW         = 10,
  parameter int LD_TIMEOUT = 0
) (
  input logic      i_clk,
  input logic      i_rst,
  inst_rom_if.slave io_bus
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMMIT, S_DONE} state_t;

  state_t          r_state;
  logic [1:0]      r_byte_cnt;
  logic [AW-1:0]   r_wr_ptr;
  logic [31:0]     r_word;
  logic            r_last_grp;
  logic            r_ld_done;
  logic [31:0]     r_inst;
  logic            r_inst_valid;
  logic [31:0]     r_mem [0:(1<<AW)-1];

  logic            w_ld_ready;
  logic            w_accept;
  logic            w_grp_end;
  logic [1:0]      w_pad_sh;
  logic [31:0]     w_word_shift;
  logic [31:0]     w_word_just;
  logic [AW-1:0]   w_rd_idx;
  logic            w_bad;

  // ld_ready drops in the same cycle ce rises so the core's fetch never races a load.
  assign w_ld_ready   = (r_state == S_COLLECT) & ~io_bus.ce;
  assign w_accept     = io_bus.ld_valid & w_ld_ready;
  assign w_grp_end    = (r_byte_cnt == 2'd3) | io_bus.ld_last;
  assign w_word_shift = {r_word[23:0], io_bus.ld_byte};
  assign w_pad_sh     = 2'd3 - r_byte_cnt;
  assign w_word_just  = w_word_shift << {w_pad_sh, 3'b000};
  assign w_rd_idx     = io_bus.pc[AW+1:2];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= 2'd0;
      r_wr_ptr   <= '0;
      r_word     <= 32'd0;
      r_last_grp <= 1'b0;
      r_ld_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!io_bus.ce && !r_ld_done) r_state <= S_COLLECT;
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_grp_end) begin
              r_word     <= w_word_just;
              r_last_grp <= io_bus.ld_last;
              r_state    <= S_COMMIT;
            end else begin
              r_word <= w_word_shift;
            end
          end
        end
        S_COMMIT: begin
          r_wr_ptr   <= r_wr_ptr + 1'b1;
          r_byte_cnt <= 2'd0;
          r_word     <= 32'd0;
          if (r_last_grp) begin
            r_state   <= S_DONE;
            r_ld_done <= 1'b1;
          end else begin
            r_state <= S_COLLECT;
          end
        end
        default: r_state <= S_DONE;
      endcase
    end
  end

  // Array is deliberately not reset: committed words must survive a core reset.
  always_ff @(posedge i_clk) begin
    if (r_state == S_COMMIT) r_mem[r_wr_ptr] <= r_word;
  end

`ifdef IMEM_ADDR_CHECK_EN
  logic r_addr_err;

  assign w_bad = (io_bus.pc[1:0] != 2'b00) | ((io_bus.pc >> (AW + 2)) != 32'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr_err <= 1'b0;
    end else if (!io_bus.ce) begin
      r_addr_err <= 1'b0;
    end else if (!io_bus.stall[1]) begin
      r_addr_err <= w_bad;
    end
  end

  assign io_bus.addr_err = r_addr_err;
`else
  logic w_unused_pc;

  assign w_bad           = 1'b0;
  assign w_unused_pc     = ^{io_bus.pc[31:AW+2], io_bus.pc[1:0]};
  assign io_bus.addr_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inst       <= 32'd0;
      r_inst_valid <= 1'b0;
    end else if (!io_bus.ce) begin
      r_inst       <= 32'd0;
      r_inst_valid <= 1'b0;
    end else if (!io_bus.stall[1]) begin
      r_inst       <= w_bad ? 32'd0 : r_mem[w_rd_idx];
      r_inst_valid <= 1'b1;
    end
  end

  logic w_unused_stall;
  assign w_unused_stall = ^{io_bus.stall[5:2], io_bus.stall[0]};

  assign io_bus.inst       = r_inst;
  assign io_bus.inst_valid = r_inst_valid;
  assign io_bus.ld_ready   = w_ld_ready;
  assign io_bus.ld_done    = r_ld_done;

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Scoreboard bench for inst_rom_ctrl: loader, fetch, stall, reset-mid-load, wrap and address aliasing.
module tb_inst_rom_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_rom_if bus ();
  inst_rom_if bus2 ();

  inst_rom_ctrl #(.AW(10)) dut  (.i_clk(clk), .i_rst(rst), .io_bus(bus));
  inst_rom_ctrl #(.AW(2))  dut2 (.i_clk(clk), .i_rst(rst), .io_bus(bus2));

`ifdef IMEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic send_byte(input bit sel, input logic [7:0] b, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    if (sel) begin
      bus2.ld_valid = 1'b1; bus2.ld_byte = b; bus2.ld_last = last;
    end else begin
      bus.ld_valid = 1'b1; bus.ld_byte = b; bus.ld_last = last;
    end
    #1;
    while (((sel ? bus2.ld_ready : bus.ld_ready) !== 1'b1) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL ld_ready_timeout sel=%0d got 0 want 1", sel);
    end
    @(negedge clk);
    if (sel) bus2.ld_valid = 1'b0;
    else     bus.ld_valid  = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.inst !== 32'd0)    begin errors++; $display("FAIL rst_inst got %h want 0", bus.inst); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %b want 0", bus.inst_valid); end
    checks++; if (bus.addr_err !== 1'b0) begin errors++; $display("FAIL rst_addr_err got %b want 0", bus.addr_err); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready got %b want 0", bus.ld_ready); end
    checks++; if (bus.ld_done !== 1'b0)  begin errors++; $display("FAIL rst_ld_done got %b want 0", bus.ld_done); end
    checks++; if (bus2.ld_done !== 1'b0) begin errors++; $display("FAIL rst_ld_done2 got %b want 0", bus2.ld_done); end
    rst = 1'b0;
  endtask

  task automatic test_load();
    logic [7:0] img [8];
    img = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    for (int i = 0; i < 8; i++) send_byte(1'b0, img[i], i == 7);
    checks++; if (bus.ld_done !== 1'b0) begin errors++; $display("FAIL ld_done_early got %b want 0", bus.ld_done); end
    @(negedge clk);
    checks++; if (bus.ld_done !== 1'b1) begin errors++; $display("FAIL ld_done got %b want 1", bus.ld_done); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL ld_ready_done got %b want 0", bus.ld_ready); end
  endtask

  task automatic test_fetch();
    logic [31:0] pcs [3];
    logic [31:0] exps [3];
    exp_t e;
    pcs  = '{32'h0, 32'h4, 32'h0};
    exps = '{32'h00112233, 32'h44556677, 32'h00112233};
    bus.stall = 6'd0;
    bus.ce = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pc = pcs[i];
      sb.push_back('{inst: exps[i], err: 1'b0});
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (bus.inst !== e.inst) begin errors++; $display("FAIL fetch_inst pc=%h got %h want %h", pcs[i], bus.inst, e.inst); end
      checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid pc=%h got %b want 1", pcs[i], bus.inst_valid); end
    end
    bus.ce = 1'b0;
    @(negedge clk);
    checks++; if (bus.inst !== 32'd0) begin errors++; $display("FAIL ce0_inst got %h want 0", bus.inst); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL ce0_valid got %b want 0", bus.inst_valid); end
  endtask

  task automatic test_stall();
    exp_t e;
    bus.ce = 1'b1;
    bus.pc = 32'h0;
    bus.stall = 6'd0;
    sb.push_back('{inst: 32'h00112233, err: 1'b0});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (bus.inst !== e.inst) begin errors++; $display("FAIL stall_pre got %h want %h", bus.inst, e.inst); end
    bus.pc = 32'h4;
    bus.stall = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{inst: 32'h00112233, err: 1'b0});
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (bus.inst !== e.inst) begin errors++; $display("FAIL stall_hold cyc=%0d got %h want %h", i, bus.inst, e.inst); end
      checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc=%0d got %b want 1", i, bus.inst_valid); end
    end
    bus.stall = 6'd0;
    sb.push_back('{inst: 32'h44556677, err: 1'b0});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (bus.inst !== e.inst) begin errors++; $display("FAIL stall_release got %h want %h", bus.inst, e.inst); end
    bus.ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_partial_rst();
    logic [31:0] pcs [5];
    exp_t        exps [5];
    exp_t        e;
    pulse_rst();
    send_byte(1'b0, 8'hCA, 1'b0);
    send_byte(1'b0, 8'hFE, 1'b0);
    bus.ce = 1'b1;
    #1;
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL ce_rise_ready got %b want 0", bus.ld_ready); end
    @(negedge clk);
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL ce_hold_ready got %b want 0", bus.ld_ready); end
    bus.ce = 1'b0;
    #1;
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL ce_fall_ready got %b want 1", bus.ld_ready); end
    send_byte(1'b0, 8'hBA, 1'b0);
    send_byte(1'b0, 8'hBE, 1'b0);
    send_byte(1'b0, 8'hAA, 1'b0);
    send_byte(1'b0, 8'hBB, 1'b1);
    @(negedge clk);
    checks++; if (bus.ld_done !== 1'b1) begin errors++; $display("FAIL partial_done got %b want 1", bus.ld_done); end
    pulse_rst();
    send_byte(1'b0, 8'h5A, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.ld_done !== 1'b0) begin errors++; $display("FAIL midload_rst_done got %b want 0", bus.ld_done); end
    @(negedge clk);
    rst = 1'b0;
    pcs  = '{32'h0, 32'h4, 32'h1000, 32'h2, 32'h0};
    exps[0] = '{inst: 32'hCAFEBABE, err: 1'b0};
    exps[1] = '{inst: 32'hAABB0000, err: 1'b0};
    exps[2] = CHK ? '{inst: 32'h0, err: 1'b1} : '{inst: 32'hCAFEBABE, err: 1'b0};
    exps[3] = CHK ? '{inst: 32'h0, err: 1'b1} : '{inst: 32'hCAFEBABE, err: 1'b0};
    exps[4] = '{inst: 32'hCAFEBABE, err: 1'b0};
    bus.ce = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.pc = pcs[i];
      sb.push_back(exps[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (bus.inst !== e.inst) begin errors++; $display("FAIL post_rst_inst pc=%h got %h want %h", pcs[i], bus.inst, e.inst); end
      checks++; if (bus.addr_err !== e.err) begin errors++; $display("FAIL addr_err pc=%h got %b want %b", pcs[i], bus.addr_err, e.err); end
    end
    bus.ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] w [5];
    exp_t        e;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) w[i][31-8*k -: 8] = 8'((i << 4) + k + 1);
    end
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) send_byte(1'b1, w[i][31-8*k -: 8], (i == 4) && (k == 3));
    end
    @(negedge clk);
    checks++; if (bus2.ld_done !== 1'b1) begin errors++; $display("FAIL wrap_done got %b want 1", bus2.ld_done); end
    bus2.stall = 6'd0;
    bus2.ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus2.pc = 32'(i * 4);
      sb.push_back('{inst: (i == 0) ? w[4] : w[i], err: 1'b0});
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (bus2.inst !== e.inst) begin errors++; $display("FAIL wrap_inst idx=%0d got %h want %h", i, bus2.inst, e.inst); end
    end
    bus2.ce = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ce = 1'b0;  bus.pc = 32'd0;  bus.stall = 6'd0;
    bus.ld_valid = 1'b0;  bus.ld_byte = 8'd0;  bus.ld_last = 1'b0;
    bus2.ce = 1'b0; bus2.pc = 32'd0; bus2.stall = 6'd0;
    bus2.ld_valid = 1'b0; bus2.ld_byte = 8'd0; bus2.ld_last = 1'b0;
    test_reset();
    test_load();
    test_fetch();
    test_stall();
    test_partial_rst();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
